bus_stall_ctrl: RTL

Arbitrates the single shared memory bus between instruction fetch (IF) and data access (MEM). Generates the pipeline stall vector `stall[5:0]` that drives the PC, if_id, id_ex, ex_mem and mem_wb registers. Merges bus-wait stalls with the ID/EX stall requests and handles flush by draining an in-flight fetch. MEM has fixed priority over IF.

---
 rtl/bus_stall_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_stall_ctrl.sv
// rtl/bus_stall_ctrl.sv - shared IF/MEM bus arbiter and pipeline stall generator
// Optional bus watchdog: define BUS_TIMEOUT_EN.
module bus_stall_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic [5:0]  stall
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DRAIN} state_t;

  state_t      state;
  logic        timeout_hit;
  logic        ack_eff;
  logic [31:0] rdata_eff;
  logic        req_mem;
  logic        req_if;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wd_cnt;

  // The watchdog substitutes for a missing ack in the cycle the limit is reached.
  assign timeout_hit = (state != IDLE) && !bus_ack && (wd_cnt == WD_LAST);
  assign bus_err     = timeout_hit && !rst;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      wd_cnt <= '0;
    end else if (!bus_ack && !timeout_hit) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  assign ack_eff   = bus_ack || timeout_hit;
  assign rdata_eff = timeout_hit ? 32'h0 : bus_rdata;

  // A fetch completing alongside a flush is discarded, so its word is never presented.
  assign if_rdata  = (state == IF_BUSY && ack_eff && !flush) ? rdata_eff : 32'h0;
  assign mem_rdata = (state == MEM_BUSY && ack_eff) ? rdata_eff : 32'h0;

  assign req_mem = mem_req && !(state == MEM_BUSY && ack_eff);
  assign req_if  = if_req && !(state == IF_BUSY && ack_eff);

  always_comb begin
    stall = 6'b000000;
    if (rst || flush) begin
      stall = 6'b000000;
    end else if (req_mem) begin
      stall = 6'b011111;
    end else if (stallreq_ex) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else if (req_if) begin
      stall = 6'b000011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_sel   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
            if (mem_req) begin
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
              bus_sel   <= mem_sel;
              state     <= MEM_BUSY;
            end else if (if_req) begin
              bus_req   <= 1'b1;
              bus_we    <= 1'b0;
              bus_addr  <= if_addr;
              bus_wdata <= 32'h0;
              bus_sel   <= 4'hF;
              state     <= IF_BUSY;
            end
          end
        end
        IF_BUSY: begin
          if (ack_eff) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        MEM_BUSY: begin
          if (ack_eff) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end
        end
        DRAIN: begin
          if (ack_eff) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
